// File: rtl/cpu_clk_pkg.sv
// Shared definitions for the CPU clock-enable generator: debounce state
// encoding, default divider rates and the compare-mask helper.
package cpu_clk_pkg;

  localparam int unsigned FAST_LOG2_DEF = 2;
  localparam int unsigned SLOW_LOG2_DEF = 25;

  typedef enum logic [1:0] {
    REL        = 2'd0,
    PRESS_WAIT = 2'd1,
    PRS        = 2'd2,
    REL_WAIT   = 2'd3
  } db_state_e;

  // Mask of the low k bits of the 32-bit divider; k >= 32 compares every bit.
  function automatic logic [31:0] ce_mask(input int unsigned k);
    if (k >= 32) return '1;
    return (32'd1 << k) - 32'd1;
  endfunction

endpackage

// File: rtl/cpu_clk_en_gen_if.sv
// Switch, button and enable/debug signals of the CPU clock-enable generator.
// The master side drives the board inputs; the slave side is the generator.
interface cpu_clk_en_gen_if;
  logic        sw2;
  logic        step_mode;
  logic        step_btn;
  logic        cpu_ce;
  logic [31:0] ce_count;
  logic        btn_db;

  modport master (
    output sw2, step_mode, step_btn,
    input  cpu_ce, ce_count, btn_db
  );

  modport slave (
    input  sw2, step_mode, step_btn,
    output cpu_ce, ce_count, btn_db
  );
endinterface

// File: rtl/cpu_clk_en_gen_btn_debounce.sv
// Two-flop synchronizer plus four-state debounce FSM for the step button.
// Produces the debounced level and a one-cycle pulse on each accepted press.
module btn_debounce
  import cpu_clk_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 1000000,
  parameter int unsigned DB_W      = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic btn_db,
  output logic press
);

  localparam logic [DB_W-1:0] LAST = DB_W'(DB_CYCLES - 1);

  logic [1:0]      sync;
  logic            btn_s;
  db_state_e       state;
  logic [DB_W-1:0] cnt;
  logic [DB_W-1:0] cnt_nxt;

  assign btn_s   = sync[1];
  assign cnt_nxt = cnt + DB_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync   <= '0;
      state  <= REL;
      cnt    <= '0;
      btn_db <= 1'b0;
      press  <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout, so every branch below sees pre-edge values.
      sync  <= {sync[0], btn};
      press <= 1'b0;
      unique case (state)
        REL: begin
          if (btn_s) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!btn_s) begin
            state <= REL;
          end else begin
            cnt <= cnt_nxt;
            if (cnt_nxt >= LAST) begin
              state  <= PRS;
              btn_db <= 1'b1;
              press  <= 1'b1;
            end
          end
        end
        PRS: begin
          if (!btn_s) begin
            state <= REL_WAIT;
            cnt   <= '0;
          end
        end
        REL_WAIT: begin
          // A bounce back to 1 returns to PRS without a new press pulse.
          if (btn_s) begin
            state <= PRS;
          end else begin
            cnt <= cnt_nxt;
            if (cnt_nxt >= LAST) begin
              state  <= REL;
              btn_db <= 1'b0;
            end
          end
        end
        default: state <= REL;
      endcase
    end
  end

endmodule

// File: rtl/cpu_clk_en_gen.sv
// CPU clock-enable generator: single-cycle cpu_ce pulses in the clk domain,
// either free-running at a switch-selected rate or one per debounced press.
module cpu_clk_en_gen
  import cpu_clk_pkg::*;
#(
  parameter int unsigned FAST_LOG2 = FAST_LOG2_DEF,
  parameter int unsigned SLOW_LOG2 = SLOW_LOG2_DEF,
  parameter int unsigned DB_CYCLES = 1000000,
  parameter int unsigned DB_W      = 20
) (
  input  logic             clk,
  input  logic             rst,
  cpu_clk_en_gen_if.slave  bus
);

  localparam logic [31:0] FAST_MASK = ce_mask(FAST_LOG2);
  localparam logic [31:0] SLOW_MASK = ce_mask(SLOW_LOG2);

  logic [1:0]  sw2_sync;
  logic [1:0]  mode_sync;
  logic        sw2_s;
  logic        step_mode_s;
  logic [31:0] div_cnt;
  logic [31:0] mask;
  logic        run_hit;
  logic        press;
  logic        btn_db;
  logic        ce_next;
  logic        cpu_ce_q;
  logic [31:0] ce_count_q;

  assign sw2_s       = sw2_sync[1];
  assign step_mode_s = mode_sync[1];

  btn_debounce #(
    .DB_CYCLES (DB_CYCLES),
    .DB_W      (DB_W)
  ) u_btn_debounce (
    .clk    (clk),
    .rst    (rst),
    .btn    (bus.step_btn),
    .btn_db (btn_db),
    .press  (press)
  );

  // The mode sampled this cycle picks the single source, so a step press and
  // a run compare landing together never yield two pulses.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    mask    = FAST_MASK;
    run_hit = 1'b0;
    ce_next = 1'b0;
    if (sw2_s) mask = SLOW_MASK;
    run_hit = ((div_cnt & mask) == mask);
    ce_next = step_mode_s ? press : run_hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sw2_sync   <= '0;
      mode_sync  <= '0;
      div_cnt    <= '0;
      cpu_ce_q   <= 1'b0;
      ce_count_q <= '0;
    end else begin
      sw2_sync  <= {sw2_sync[0], bus.sw2};
      mode_sync <= {mode_sync[0], bus.step_mode};
      div_cnt   <= div_cnt + 32'd1;
      cpu_ce_q  <= ce_next;
      if (ce_next) ce_count_q <= ce_count_q + 32'd1;
    end
  end

  assign bus.cpu_ce   = cpu_ce_q;
  assign bus.ce_count = ce_count_q;
  assign bus.btn_db   = btn_db;

endmodule

// File: tb/tb_cpu_clk_en_gen.sv
// Directed bench for cpu_clk_en_gen: reset, run fast/slow with rate switching,
// step mode with bounce, re-press, short glitch and reset during debounce.
module tb_cpu_clk_en_gen;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  cpu_clk_en_gen_if bus ();

  cpu_clk_en_gen #(
    .FAST_LOG2 (2),
    .SLOW_LOG2 (4),
    .DB_CYCLES (4),
    .DB_W      (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  // Expected cpu_ce at sample k, k counted in falling edges after reset release.
  function automatic logic exp_ce_at(input int k);
    if (k <= 40)  return (k % 4) == 0;
    if (k <= 84)  return (k % 16) == 0;
    if (k <= 100) return (k % 4) == 0;
    if (k <= 174) return (k == 116) || (k == 142);
    return k == 183;
  endfunction

  function automatic logic exp_db_at(input int k);
    if (k < 115)  return 1'b0;
    if (k <= 130) return 1'b1;
    if (k <= 140) return 1'b0;
    if (k <= 165) return 1'b1;
    if (k <= 181) return 1'b0;
    return 1'b1;
  endfunction

  initial begin
    logic        e_ce;
    logic        e_db;
    logic [31:0] e_cnt;

    n_checks = 0;
    n_pass   = 0;
    rst           = 1'b1;
    bus.sw2       = 1'b0;
    bus.step_mode = 1'b0;
    bus.step_btn  = 1'b0;

    // Reset held for three rising edges while the button toggles.
    for (int i = 0; i < 3; i++) begin
      bus.step_btn = ~bus.step_btn;
      @(negedge clk);
      check($sformatf("rst_ce%0d", i),  32'(bus.cpu_ce), 32'd0);
      check($sformatf("rst_cnt%0d", i), bus.ce_count,    32'd0);
      check($sformatf("rst_db%0d", i),  32'(bus.btn_db), 32'd0);
    end
    rst          = 1'b0;
    bus.step_btn = 1'b0;

    e_cnt = '0;
    for (int k = 1; k <= 190; k++) begin
      @(negedge clk);
      e_ce = exp_ce_at(k);
      e_db = exp_db_at(k);
      if (k == 175 || k == 176) e_cnt = '0;
      if (e_ce) e_cnt = e_cnt + 32'd1;
      check($sformatf("ce@%0d", k),  32'(bus.cpu_ce), 32'(e_ce));
      check($sformatf("cnt@%0d", k), bus.ce_count,    e_cnt);
      check($sformatf("db@%0d", k),  32'(bus.btn_db), 32'(e_db));

      unique case (k)
        40:  bus.sw2       = 1'b1;   // to slow
        84:  bus.sw2       = 1'b0;   // back to fast mid-interval
        100: bus.step_mode = 1'b1;
        105: bus.step_btn  = 1'b1;   // bounce 1,0,1,0 then hold
        106: bus.step_btn  = 1'b0;
        107: bus.step_btn  = 1'b1;
        108: bus.step_btn  = 1'b0;
        109: bus.step_btn  = 1'b1;
        125: bus.step_btn  = 1'b0;   // release 10 cycles
        135: bus.step_btn  = 1'b1;   // re-press
        145: bus.step_btn  = 1'b0;   // short release glitch
        147: bus.step_btn  = 1'b1;
        160: bus.step_btn  = 1'b0;
        170: bus.step_btn  = 1'b1;   // press, then reset during PRESS_WAIT
        174: rst           = 1'b1;
        176: rst           = 1'b0;
        default: ;
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cpu_clk_en_gen.md
Name: cpu_clk_en_gen

Overview:
- Fast-domain counterpart to the board clock divider.
- Instead of driving a derived clock, it produces a single-cycle clock-enable pulse (cpu_ce) in the `clk` domain for the CPU core.
- Two modes: continuous run at a switch-selected rate, or one pulse per debounced push-button press (single step).
- Also reports the total number of enables issued, for the seven-segment/debug display.

Parameters:
- FAST_LOG2, 2: run-mode fast rate is one pulse per 2^FAST_LOG2 clk cycles.
- SLOW_LOG2, 25: run-mode slow rate is one pulse per 2^SLOW_LOG2 clk cycles.
- DB_CYCLES, 1000000: consecutive stable samples required to accept a button level change.
- DB_W, 20: width of the debounce counter; must satisfy 2^DB_W > DB_CYCLES.

Ports:
- clk  in  1  board clock; the only clock in the block.
- rst  in  1  synchronous, active-high reset.
- sw2  in  1  rate select: 1 = slow (SLOW_LOG2), 0 = fast (FAST_LOG2); asynchronous switch.
- step_mode  in  1  1 = single-step, 0 = run; asynchronous switch.
- step_btn  in  1  raw push button, active high, bouncing, asynchronous.
- cpu_ce  out  1  one-clk-cycle enable pulse to the CPU.
- ce_count  out  32  number of cpu_ce pulses since reset.
- btn_db  out  1  debounced button level, for an LED.

Behaviour:
- Reset:
  - Synchronous, active-high: every register updates only on posedge clk while rst=1.
  - While rst=1 and on the first cycle after it: cpu_ce=0, ce_count=0, btn_db=0.
  - Also cleared by reset: div_cnt=0, both synchronizer chains, debounce FSM in REL, debounce counter 0.
  - Reset mid-pulse or mid-debounce aborts with no residual pulse.
- Synchronizers:
  - sw2, step_mode and step_btn each pass through a 2-FF synchronizer.
  - The synced versions are used below; total input latency is 2 cycles.
- Run mode (step_mode_s=0):
  - div_cnt is a free-running 32-bit counter that wraps 0xFFFFFFFF->0.
  - cpu_ce=1 (registered) in the cycle after div_cnt[K-1:0] is all ones, where K = SLOW_LOG2 if sw2_s else FAST_LOG2.
  - Fast rate: exactly one pulse per 2^FAST_LOG2 cycles.
  - A rate change takes effect on the next compare; div_cnt is not cleared.
  - The first pulse after a change may come early, but never two pulses in consecutive cycles unless FAST_LOG2=0.
- Debounce FSM (always running, independent of mode):
  - States: REL, PRESS_WAIT, PRS, REL_WAIT.
  - REL: btn_s=1 -> PRESS_WAIT, cnt=0.
  - PRESS_WAIT: btn_s=0 -> REL. Otherwise cnt++; when cnt==DB_CYCLES-1 -> PRS and btn_db<=1.
  - PRS: btn_s=0 -> REL_WAIT, cnt=0.
  - REL_WAIT: btn_s=1 -> PRS. Otherwise cnt++; when cnt==DB_CYCLES-1 -> REL and btn_db<=0.
  - btn_db is high exactly in PRS and REL_WAIT.
- Step mode (step_mode_s=1):
  - The run-mode compare is ignored.
  - cpu_ce=1 for exactly one cycle, in the cycle after the PRESS_WAIT->PRS transition.
  - Holding the button produces no further pulses; release-then-press produces another.
- Mode switching:
  - Entering step mode with the button held (state PRS) produces no pulse.
  - Leaving step mode resumes run pulses at the next compare.
  - A step event and a run compare can coincide in the switching cycle. At most one pulse is issued; the mode sampled that cycle decides which source applies.
- ce_count:
  - Increments by 1 in the same cycle cpu_ce=1, so the count is visible together with the pulse.
  - Wraps 0xFFFFFFFF->0.

Decomposition:
- Shared package cpu_clk_pkg holds:
  - debounce state encoding (REL=2'd0, PRESS_WAIT=2'd1, PRS=2'd2, REL_WAIT=2'd3);
  - default FAST_LOG2/SLOW_LOG2.
- One sub-module, btn_debounce: synchronizer plus the debounce FSM.
  - Parameters DB_CYCLES and DB_W.
  - Outputs the level btn_db and a one-cycle press pulse.
- The top block contains the input synchronizers, div_cnt, mode mux, cpu_ce register and ce_count.

Test Plan:
(all scenarios use FAST_LOG2=2, SLOW_LOG2=4, DB_CYCLES=4)
- Reset:
  - Hold rst=1 for 3 cycles with step_btn toggling -> cpu_ce=0, ce_count=0, btn_db=0 throughout and on the first cycle after release.
- Run fast:
  - step_mode=0, sw2=0, 40 cycles -> cpu_ce pulses exactly every 4 cycles, each 1 cycle wide.
  - ce_count goes 1, 2, … and reaches 9 or 10 at cycle 40, matching the pulse count.
- Run slow / switch:
  - sw2=1 -> pulses every 16 cycles.
  - Toggle sw2 mid-interval -> never two adjacent pulses; the new period is established within one period.
- Step with bounce:
  - step_mode=1, btn pattern 1,0,1,0 then held 1 for 10 cycles -> exactly one cpu_ce, 1 cycle after btn_db rises (btn_db rises 2+4 cycles after the stable 1).
  - Holding the button gives no more pulses.
- Re-press:
  - Release for 10 cycles, then press for 10 -> a second pulse; ce_count=2.
  - A release glitch shorter than 4 cycles produces no extra pulse.
- Reset mid-debounce:
  - rst asserted during PRESS_WAIT -> no pulse; the FSM restarts from REL; a subsequent valid press gives exactly one pulse.
